// File: rtl/bitslam_voice_sched_if.sv
// Host bus for bitslam_voice_sched: 6-bit multiplexed address/data.
// Master drives the bus, the scheduler listens on the slave side.
interface bitslam_voice_sched_if;
  logic       addr_data_sel;
  logic [5:0] addr_data;

  modport master (
    output addr_data_sel,
    output addr_data
  );

  modport slave (
    input addr_data_sel,
    input addr_data
  );
endinterface

// File: rtl/bitslam_voice_sched.sv
// Round-robin LFSR noise scheduler with registered volume mixer.
// Optional 7-bit short mode: define BITSLAM_SHORT_MODE_EN.
module bitslam_voice_sched #(
  parameter int NUM_VOICES = 4,
  parameter int MIX_W      = 4 + $clog2(NUM_VOICES)
) (
  input  logic                 clk,
  input  logic                 rst,
  bitslam_voice_sched_if.slave host,
  output logic [MIX_W-1:0]     mix_out
);
  localparam int SW = $clog2(NUM_VOICES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_VOICES - 1);

  logic [5:0]            addr_q, addr_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [5:0]            period_q [NUM_VOICES];
  logic [5:0]            period_d [NUM_VOICES];
  logic [3:0]            volume_q [NUM_VOICES];
  logic [3:0]            volume_d [NUM_VOICES];
  logic [5:0]            cnt_q    [NUM_VOICES];
  logic [5:0]            cnt_d    [NUM_VOICES];
  logic [7:0]            lfsr_q   [NUM_VOICES];
  logic [7:0]            lfsr_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0] short_v;
  logic [MIX_W-1:0]      mix_q, mix_d;

`ifdef BITSLAM_SHORT_MODE_EN
  logic [NUM_VOICES-1:0] short_q, short_d;
  assign short_v = short_q;
`else
  assign short_v = '0;
`endif

  logic [3:0] wr_v;
  logic [1:0] wr_r;
  logic [5:0] wdata;
  logic       wr_en;

  assign wr_v  = addr_q[5:2];
  assign wr_r  = addr_q[1:0];
  assign wdata = host.addr_data;
  // Out-of-range voices and reg3 are dropped here, never aliased.
  assign wr_en = host.addr_data_sel
              && ({1'b0, wr_v} < 5'(NUM_VOICES))
              && (wr_r != 2'd3);

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] l,
    input logic       sh
  );
    logic [7:0] n;
    if (sh) begin
      if (l[6:0] == 7'd0) n = 8'h01;
      else                n = {1'b0, l[5:0], l[5] ^ l[6]};
    end else begin
      if (l == 8'd0) n = 8'h01;
      else           n = {l[6:0], l[3] ^ l[6] ^ l[7]};
    end
    return n;
  endfunction

  always_comb begin
    logic hit;
    hit    = 1'b0;
    addr_d = host.addr_data_sel ? addr_q : host.addr_data;
    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    en_d   = en_q;
`ifdef BITSLAM_SHORT_MODE_EN
    short_d = short_q;
`endif
    for (int v = 0; v < NUM_VOICES; v++) begin
      period_d[v] = period_q[v];
      volume_d[v] = volume_q[v];
      cnt_d[v]    = cnt_q[v];
      lfsr_d[v]   = lfsr_q[v];
      // Compare against the old period so a same-cycle write waits a visit.
      if (en_q[v] && (slot_q == SW'(v))) begin
        if (cnt_q[v] >= period_q[v]) begin
          cnt_d[v]  = '0;
          lfsr_d[v] = lfsr_step(lfsr_q[v], short_v[v]);
        end else begin
          cnt_d[v] = cnt_q[v] + 6'd1;
        end
      end
      hit = wr_en && (wr_v == 4'(v));
      if (hit) begin
        unique case (1'b1)
          wr_r == 2'd0: period_d[v] = wdata;
          wr_r == 2'd1: volume_d[v] = wdata[3:0];
          default: begin
            en_d[v] = wdata[0];
`ifdef BITSLAM_SHORT_MODE_EN
            short_d[v] = wdata[2];
`endif
            // Retrigger overrides any step taken this cycle.
            if (wdata[1]) begin
              cnt_d[v]  = '0;
              lfsr_d[v] = 8'h01;
            end
          end
        endcase
      end
    end
    mix_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (en_q[v] && lfsr_q[v][0]) begin
        mix_d = mix_d + MIX_W'(volume_q[v]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      slot_q <= '0;
      en_q   <= '0;
      mix_q  <= '0;
`ifdef BITSLAM_SHORT_MODE_EN
      short_q <= '0;
`endif
      for (int v = 0; v < NUM_VOICES; v++) begin
        period_q[v] <= '0;
        volume_q[v] <= '0;
        cnt_q[v]    <= '0;
        lfsr_q[v]   <= 8'h01;
      end
    end else begin
      addr_q   <= addr_d;
      slot_q   <= slot_d;
      en_q     <= en_d;
      mix_q    <= mix_d;
`ifdef BITSLAM_SHORT_MODE_EN
      short_q  <= short_d;
`endif
      period_q <= period_d;
      volume_q <= volume_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign mix_out = mix_q;

endmodule

// File: tb/tb_bitslam_voice_sched.sv
// Directed self-checking bench for bitslam_voice_sched.
// NUM_VOICES=4, MIX_W=6; observes mix_out only.
module tb_bitslam_voice_sched;
  logic       clk;
  logic       rst;
  logic [5:0] mix_out;
  int         checks;
  int         failures;
  int         cyc;

  bitslam_voice_sched_if host();

  bitslam_voice_sched #(
    .NUM_VOICES(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .host   (host),
    .mix_out(mix_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge index since reset release; index k services slot k%4.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [7:0] seq [8];
  initial begin
    seq = '{8'h01, 8'h02, 8'h04, 8'h08,
            8'h11, 8'h22, 8'h44, 8'h89};
  end

  function automatic logic sbit(int n);
    logic [7:0] t;
    t = seq[n];
    return t[0];
  endfunction

  task automatic do_reset();
    host.addr_data_sel = 1'b0;
    host.addr_data     = 6'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a,
                    input logic [5:0] d);
    @(negedge clk);
    host.addr_data_sel = 1'b0;
    host.addr_data     = a;
    @(negedge clk);
    host.addr_data_sel = 1'b1;
    host.addr_data     = d;
    @(negedge clk);
    host.addr_data_sel = 1'b0;
  endtask

  // Data phase lands on the posedge servicing slot s.
  task automatic wr_at(input logic [5:0] a,
                       input logic [5:0] d,
                       input int s);
    @(negedge clk);
    host.addr_data_sel = 1'b0;
    host.addr_data     = a;
    @(negedge clk);
    while (cyc % 4 != s) @(negedge clk);
    host.addr_data_sel = 1'b1;
    host.addr_data     = d;
    @(negedge clk);
    host.addr_data_sel = 1'b0;
  endtask

  // Data phase lands on absolute posedge index k.
  task automatic wr_k(input logic [5:0] a,
                      input logic [5:0] d,
                      input int k);
    @(negedge clk);
    host.addr_data_sel = 1'b0;
    host.addr_data     = a;
    while (cyc < k) @(negedge clk);
    host.addr_data_sel = 1'b1;
    host.addr_data     = d;
    @(negedge clk);
    host.addr_data_sel = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic setup_all();
    for (int v = 0; v < 4; v++) begin
      wr(6'(4 * v),     6'd63);
      wr(6'(4 * v + 1), 6'd15);
      wr(6'(4 * v + 2), 6'd3);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (mix_out !== 6'd0) begin
      failures++;
      $display("FAIL reset_hold mix_out=%0d exp=0", mix_out);
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (mix_out !== 6'd0) begin
        failures++;
        $display("FAIL reset_idle[%0d] mix_out=%0d exp=0",
                 i, mix_out);
      end
    end
  endtask

  task automatic test_single_voice();
    int base;
    logic [5:0] exp;
    do_reset();
    wr(6'd1, 6'd15);
    wr_at(6'd2, 6'd3, 0);
    base = cyc - 1;
    for (int i = 0; i < 32; i++) begin
      wait_cyc(base + 2 + i);
      exp = sbit(i / 4) ? 6'd15 : 6'd0;
      checks++;
      if (mix_out !== exp) begin
        failures++;
        $display("FAIL single_voice[%0d] mix_out=%0d exp=%0d",
                 i, mix_out, exp);
      end
    end
  endtask

  task automatic test_two_voices();
    int base;
    logic [5:0] exp;
    do_reset();
    wr(6'd4, 6'd2);
    wr(6'd5, 6'd7);
    wr_at(6'd6, 6'd3, 1);
    base = cyc - 1;
    for (int i = 0; i < 60; i++) begin
      wait_cyc(base + 2 + i);
      exp = sbit(i / 12) ? 6'd7 : 6'd0;
      checks++;
      if (mix_out !== exp) begin
        failures++;
        $display("FAIL v1_period2[%0d] mix_out=%0d exp=%0d",
                 i, mix_out, exp);
      end
    end
  endtask

  task automatic test_all_voices();
    do_reset();
    setup_all();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (mix_out !== 6'd60) begin
        failures++;
        $display("FAIL all_voices[%0d] mix_out=%0d exp=60",
                 i, mix_out);
      end
    end
    wr(6'd6, 6'd0);
    @(negedge clk);
    checks++;
    if (mix_out !== 6'd45) begin
      failures++;
      $display("FAIL disable_v1 mix_out=%0d exp=45", mix_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    setup_all();
    @(negedge clk);
    checks++;
    if (mix_out !== 6'd60) begin
      failures++;
      $display("FAIL pre_reset mix_out=%0d exp=60", mix_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mix_out !== 6'd0) begin
      failures++;
      $display("FAIL async_reset mix_out=%0d exp=0", mix_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (mix_out !== 6'd0) begin
        failures++;
        $display("FAIL post_reset[%0d] mix_out=%0d exp=0",
                 i, mix_out);
      end
    end
  endtask

  task automatic test_retrig_collision();
    int base;
    logic [5:0] exp;
    do_reset();
    wr(6'd1, 6'd15);
    wr(6'd2, 6'd1);
    repeat (13) @(negedge clk);
    wr_at(6'd2, 6'd3, 0);
    base = cyc - 1;
    for (int i = 0; i < 16; i++) begin
      wait_cyc(base + 2 + i);
      exp = sbit(i / 4) ? 6'd15 : 6'd0;
      checks++;
      if (mix_out !== exp) begin
        failures++;
        $display("FAIL retrig_collide[%0d] mix_out=%0d exp=%0d",
                 i, mix_out, exp);
      end
    end
  endtask

  task automatic test_period_collision();
    int base;
    logic [5:0] exp;
    do_reset();
    wr(6'd1, 6'd15);
    wr_at(6'd2, 6'd3, 0);
    base = cyc - 1;
    wr_k(6'd0, 6'd5, base + 4);
    for (int i = 4; i < 12; i++) begin
      wait_cyc(base + 2 + i);
      checks++;
      if (mix_out !== 6'd0) begin
        failures++;
        $display("FAIL period_old_used[%0d] mix_out=%0d exp=0",
                 i, mix_out);
      end
    end
    for (int i = 74; i < 80; i++) begin
      wait_cyc(base + 2 + i);
      exp = (i >= 76) ? 6'd15 : 6'd0;
      checks++;
      if (mix_out !== exp) begin
        failures++;
        $display("FAIL period_new[%0d] mix_out=%0d exp=%0d",
                 i, mix_out, exp);
      end
    end
  endtask

  task automatic test_period_lower();
    int base;
    logic [5:0] exp;
    do_reset();
    wr(6'd1, 6'd15);
    wr(6'd0, 6'd63);
    wr_at(6'd2, 6'd3, 0);
    base = cyc - 1;
    wr_k(6'd0, 6'd2, base + 41);
    for (int i = 40; i < 48; i++) begin
      wait_cyc(base + 2 + i);
      exp = (i >= 44) ? 6'd0 : 6'd15;
      checks++;
      if (mix_out !== exp) begin
        failures++;
        $display("FAIL period_lower[%0d] mix_out=%0d exp=%0d",
                 i, mix_out, exp);
      end
    end
  endtask

  task automatic test_ignored_writes();
    logic [5:0] wa [6];
    logic [5:0] wd [6];
    wa = '{6'h3C, 6'h3E, 6'h03, 6'h12, 6'h11, 6'h3D};
    wd = '{6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    do_reset();
    wr(6'd0, 6'd63);
    wr(6'd1, 6'h3F);
    wr(6'd2, 6'd3);
    @(negedge clk);
    checks++;
    if (mix_out !== 6'd15) begin
      failures++;
      $display("FAIL vol_mask mix_out=%0d exp=15", mix_out);
    end
    for (int i = 0; i < 6; i++) begin
      wr(wa[i], wd[i]);
      repeat (2) @(negedge clk);
      checks++;
      if (mix_out !== 6'd15) begin
        failures++;
        $display("FAIL ignored_wr addr=%0h mix_out=%0d exp=15",
                 wa[i], mix_out);
      end
    end
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    rst                = 1'b1;
    host.addr_data_sel = 1'b0;
    host.addr_data     = 6'd0;
    test_reset();
    test_single_voice();
    test_two_voices();
    test_all_voices();
    test_reset_mid();
    test_retrig_collision();
    test_period_collision();
    test_period_lower();
    test_ignored_writes();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
